otg_hpi_bus_master: RTL and testbench

Avalon-MM slave that runs complete Host Port Interface (HPI) bus cycles to the CY7C67200 USB OTG controller. Each Avalon read or write becomes one sequenced HPI cycle with programmable setup, strobe and hold phases. Read data is captured from the chip. This block replaces the separate software-toggled address/data/cs/rd/wr PIOs with a single hardware-timed bridge. It sits between the system interconnect and the top-level OTG pins; the bidirectional pad is resolved at top level.

---
 rtl/otg_hpi_pkg.sv | 28 ++
 rtl/hpi_phase_counter.sv | 26 ++
 rtl/otg_hpi_bus_master.sv | 137 +++++++++++++
 tb/tb_otg_hpi_bus_master.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/otg_hpi_pkg.sv
// Shared types and constants for the CY7C67200 HPI bus master.
package otg_hpi_pkg;

   localparam int HPI_DW = 16;

   localparam logic [1:0] HPI_REG_DATA    = 2'd0;
   localparam logic [1:0] HPI_REG_MAILBOX = 2'd1;
   localparam logic [1:0] HPI_REG_ADDRESS = 2'd2;
   localparam logic [1:0] HPI_REG_STATUS  = 2'd3;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      HOLD,
      ACK
   } hpi_state_e;

   // Wide enough to hold the longest phase length minus one.
   function automatic int phase_cnt_width(input int s, input int t, input int h);
      int m;
      m = s;
      if (t > m) m = t;
      if (h > m) m = h;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/hpi_phase_counter.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
module hpi_phase_counter #(
   parameter int W = 3
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         tc_o
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/otg_hpi_bus_master.sv
// Avalon-MM slave that turns each read/write into one timed HPI bus cycle.
module otg_hpi_bus_master
   import otg_hpi_pkg::*;
#(
   parameter int SETUP_CYCLES  = 2,
   parameter int STROBE_CYCLES = 6,
   parameter int HOLD_CYCLES   = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              read,
   input  logic              write,
   input  logic [HPI_DW-1:0] writedata,
   output logic [HPI_DW-1:0] readdata,
   output logic              waitrequest,
   output logic [1:0]        hpi_addr,
   output logic              hpi_cs_n,
   output logic              hpi_rd_n,
   output logic              hpi_wr_n,
   output logic [HPI_DW-1:0] hpi_dout,
   output logic              hpi_oe,
   input  logic [HPI_DW-1:0] hpi_din
);

   localparam int CW = phase_cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);

   hpi_state_e        state_q;
   logic              is_wr_q;
   logic [1:0]        addr_q;
   logic [HPI_DW-1:0] dout_q;
   logic [HPI_DW-1:0] rdata_q;
   logic              cs_n_q, rd_n_q, wr_n_q, oe_q, wait_q;

   logic              req;
   logic              tc;
   logic              cnt_load_d;
   logic [CW-1:0]     cnt_val_d;

   assign req = chipselect && (read || write);

   // Counter is reloaded on the same edge that enters each timed phase.
   always_comb begin
      cnt_load_d = 1'b0;
      cnt_val_d  = '0;
      case (state_q)
         IDLE: begin
            cnt_load_d = req;
            cnt_val_d  = CW'(SETUP_CYCLES - 1);
         end
         SETUP: begin
            cnt_load_d = tc;
            cnt_val_d  = CW'(STROBE_CYCLES - 1);
         end
         STROBE: begin
            cnt_load_d = tc;
            cnt_val_d  = CW'(HOLD_CYCLES - 1);
         end
         default: ;
      endcase
   end

   hpi_phase_counter #(.W(CW)) u_phase_cnt (
      .clk_i      (clk),
      .rst_i      (reset),
      .load_i     (cnt_load_d),
      .load_val_i (cnt_val_d),
      .tc_o       (tc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         is_wr_q <= 1'b0;
         addr_q  <= '0;
         dout_q  <= '0;
         rdata_q <= '0;
         cs_n_q  <= 1'b1;
         rd_n_q  <= 1'b1;
         wr_n_q  <= 1'b1;
         oe_q    <= 1'b0;
         wait_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (req) begin
                  state_q <= SETUP;
                  is_wr_q <= write;
                  addr_q  <= address;
                  dout_q  <= writedata;
                  cs_n_q  <= 1'b0;
                  oe_q    <= write;
               end
            end
            SETUP: begin
               if (tc) begin
                  state_q <= STROBE;
                  rd_n_q  <= is_wr_q;
                  wr_n_q  <= !is_wr_q;
               end
            end
            STROBE: begin
               if (tc) begin
                  state_q <= HOLD;
                  rd_n_q  <= 1'b1;
                  wr_n_q  <= 1'b1;
                  if (!is_wr_q) rdata_q <= hpi_din;
               end
            end
            HOLD: begin
               if (tc) begin
                  state_q <= ACK;
                  cs_n_q  <= 1'b1;
                  oe_q    <= 1'b0;
                  wait_q  <= 1'b0;
               end
            end
            ACK: begin
               state_q <= IDLE;
               wait_q  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign readdata    = rdata_q;
   assign waitrequest = wait_q;
   assign hpi_addr    = addr_q;
   assign hpi_cs_n    = cs_n_q;
   assign hpi_rd_n    = rd_n_q;
   assign hpi_wr_n    = wr_n_q;
   assign hpi_dout    = dout_q;
   assign hpi_oe      = oe_q;

endmodule

// File: tb/tb_otg_hpi_bus_master.sv
// Checks two HPI bus master configurations (2/6/2 and 1/1/1) against a cycle-offset model.
module tb_otg_hpi_bus_master;

   localparam int SC [2] = '{2, 1};
   localparam int TC [2] = '{6, 1};
   localparam int HC [2] = '{2, 1};

   // Hand-computed timing expectations per configuration
   localparam int ACK_LIT  [2] = '{11, 4};
   localparam int SFST_LIT [2] = '{3, 2};
   localparam int SLST_LIT [2] = '{8, 2};
   localparam int CSLO_LIT [2] = '{10, 3};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic        cs [2], rd [2], wr [2];
   logic [1:0]  addr [2];
   logic [15:0] wdata [2], din [2];
   logic [15:0] rdata [2], dout [2];
   logic        waitreq [2], cs_n [2], rd_n [2], wr_n [2], oe [2];
   logic [1:0]  haddr [2];
   bit          beef_mode [2];

   otg_hpi_bus_master #(.SETUP_CYCLES(2), .STROBE_CYCLES(6), .HOLD_CYCLES(2)) dut0 (
      .clk(clk), .reset(reset), .address(addr[0]), .chipselect(cs[0]),
      .read(rd[0]), .write(wr[0]), .writedata(wdata[0]), .readdata(rdata[0]),
      .waitrequest(waitreq[0]), .hpi_addr(haddr[0]), .hpi_cs_n(cs_n[0]),
      .hpi_rd_n(rd_n[0]), .hpi_wr_n(wr_n[0]), .hpi_dout(dout[0]), .hpi_oe(oe[0]),
      .hpi_din(din[0])
   );

   otg_hpi_bus_master #(.SETUP_CYCLES(1), .STROBE_CYCLES(1), .HOLD_CYCLES(1)) dut1 (
      .clk(clk), .reset(reset), .address(addr[1]), .chipselect(cs[1]),
      .read(rd[1]), .write(wr[1]), .writedata(wdata[1]), .readdata(rdata[1]),
      .waitrequest(waitreq[1]), .hpi_addr(haddr[1]), .hpi_cs_n(cs_n[1]),
      .hpi_rd_n(rd_n[1]), .hpi_wr_n(wr_n[1]), .hpi_dout(dout[1]), .hpi_oe(oe[1]),
      .hpi_din(din[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Pad model: random data, or 0xBEEF whenever the read strobe is low.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++)
         din[g] <= (beef_mode[g] && rd_n[g] == 1'b0) ? 16'hBEEF : 16'($urandom);
   end

   // Model: k is the 1-based cycle index inside the current HPI transaction.
   bit          busy [2];
   int          k [2];
   bit          m_wr [2];
   logic [1:0]  m_addr [2];
   logic [15:0] m_data [2], m_rd [2];

   always @(posedge clk or posedge reset) begin
      for (int g = 0; g < 2; g++) begin
         if (reset) begin
            busy[g] <= 1'b0;
            k[g]    <= 0;
            m_rd[g] <= '0;
         end else if (busy[g]) begin
            if (k[g] == SC[g] + TC[g] && !m_wr[g]) m_rd[g] <= din[g];
            if (k[g] == SC[g] + TC[g] + HC[g] + 1) busy[g] <= 1'b0;
            else k[g] <= k[g] + 1;
         end else if (cs[g] && (rd[g] || wr[g])) begin
            busy[g]   <= 1'b1;
            k[g]      <= 1;
            m_wr[g]   <= wr[g];
            m_addr[g] <= addr[g];
            m_data[g] <= wdata[g];
         end
      end
   end

   bit e_act, e_rd, e_wr, e_ack;
   always @(negedge clk) begin
      if (!reset) begin
         for (int g = 0; g < 2; g++) begin
            e_act = busy[g] && k[g] <= SC[g] + TC[g] + HC[g];
            e_rd  = busy[g] && k[g] > SC[g] && k[g] <= SC[g] + TC[g] && !m_wr[g];
            e_wr  = busy[g] && k[g] > SC[g] && k[g] <= SC[g] + TC[g] && m_wr[g];
            e_ack = busy[g] && k[g] == SC[g] + TC[g] + HC[g] + 1;
            chk($sformatf("cfg%0d hpi_cs_n", g), cs_n[g], !e_act);
            chk($sformatf("cfg%0d hpi_rd_n", g), rd_n[g], !e_rd);
            chk($sformatf("cfg%0d hpi_wr_n", g), wr_n[g], !e_wr);
            chk($sformatf("cfg%0d hpi_oe", g), oe[g], e_act && m_wr[g]);
            chk($sformatf("cfg%0d waitrequest", g), waitreq[g], !e_ack);
            chk($sformatf("cfg%0d readdata", g), rdata[g], m_rd[g]);
            if (e_act) chk($sformatf("cfg%0d hpi_addr", g), haddr[g], m_addr[g]);
            if (e_act && m_wr[g]) chk($sformatf("cfg%0d hpi_dout", g), dout[g], m_data[g]);
         end
      end
   end

   // Observations from the most recent directed transaction
   int          r_ack, r_sfirst, r_slast, r_rdlow, r_wrlow, r_cslow;
   logic [15:0] r_rdack, r_dout;

   // Drive a request at the current negedge and watch it until waitrequest drops.
   task automatic txn(input int d, input bit r, input bit w, input logic [1:0] a,
                      input logic [15:0] wd);
      cs[d] = 1'b1; rd[d] = r; wr[d] = w; addr[d] = a; wdata[d] = wd;
      r_ack = -1; r_sfirst = -1; r_slast = -1; r_rdlow = 0; r_wrlow = 0; r_cslow = 0;
      r_rdack = 'x; r_dout = 'x;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (!cs_n[d]) r_cslow++;
         if (!rd_n[d]) r_rdlow++;
         if (!wr_n[d]) begin
            r_wrlow++;
            r_dout = dout[d];
         end
         if (!rd_n[d] || !wr_n[d]) begin
            if (r_sfirst < 0) r_sfirst = c;
            r_slast = c;
         end
         if (!waitreq[d]) begin
            r_ack   = c;
            r_rdack = rdata[d];
            break;
         end
      end
      chk($sformatf("cfg%0d ack cycle", d), r_ack, ACK_LIT[d]);
   endtask

   task automatic go_idle(input int d, input int n);
      cs[d] = 1'b0;
      rd[d] = 1'($urandom);
      wr[d] = 1'($urandom);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      for (int g = 0; g < 2; g++) begin
         cs[g] = 0; rd[g] = 0; wr[g] = 0; addr[g] = 0; wdata[g] = 0; beef_mode[g] = 0;
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         chk("reset readdata", rdata[g], 16'h0);
         chk("reset hpi_addr", haddr[g], 2'd0);
         chk("reset hpi_dout", dout[g], 16'h0);
         chk("reset cs_n/rd_n/wr_n/oe/wait",
             {cs_n[g], rd_n[g], wr_n[g], oe[g], waitreq[g]}, 5'b11101);
      end
      reset = 1'b0;
      @(negedge clk);

      for (int d = 0; d < 2; d++) begin
         txn(d, 1'b0, 1'b1, 2'd2, 16'h1234);
         chk("write strobe first", r_sfirst, SFST_LIT[d]);
         chk("write strobe last", r_slast, SLST_LIT[d]);
         chk("write cs_n low cycles", r_cslow, CSLO_LIT[d]);
         chk("write rd_n low cycles", r_rdlow, 0);
         chk("write dout", r_dout, 16'h1234);
         @(negedge clk);
         go_idle(d, 2);

         beef_mode[d] = 1'b1;
         txn(d, 1'b1, 1'b0, 2'd0, 16'h5555);
         chk("read rd_n low cycles", r_rdlow, TC[d]);
         chk("read strobe first", r_sfirst, SFST_LIT[d]);
         chk("read data at ack", r_rdack, 16'hBEEF);
         beef_mode[d] = 1'b0;
         @(negedge clk);

         // Back-to-back: next request already present in the IDLE cycle after ACK.
         txn(d, 1'b0, 1'b1, 2'd1, 16'hA5A5);
         @(negedge clk);
         txn(d, 1'b1, 1'b0, 2'd3, 16'h0000);
         @(negedge clk);
         go_idle(d, 1);

         txn(d, 1'b1, 1'b1, 2'd1, 16'h00FF);
         chk("rd+wr rd_n low cycles", r_rdlow, 0);
         chk("rd+wr wr_n low cycles", r_wrlow, TC[d]);
         chk("rd+wr dout", r_dout, 16'h00FF);
         @(negedge clk);
         go_idle(d, 1);

         for (int i = 0; i < 40; i++) begin
            bit r, w;
            int gap;
            r = 1'($urandom);
            w = 1'($urandom);
            if (!r && !w) r = 1'b1;
            beef_mode[d] = 1'($urandom);
            txn(d, r, w, 2'($urandom), 16'($urandom));
            @(negedge clk);
            gap = $urandom_range(0, 3);
            if (gap > 0) go_idle(d, gap);
         end
         beef_mode[d] = 1'b0;
         go_idle(d, 2);
      end

      // Asynchronous reset in the middle of a write strobe
      cs[0] = 1'b1; rd[0] = 1'b0; wr[0] = 1'b1; addr[0] = 2'd3; wdata[0] = 16'hCAFE;
      for (int c = 0; c < 20 && wr_n[0] !== 1'b0; c++) @(negedge clk);
      chk("wr_n low before reset", wr_n[0], 1'b0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async reset cs_n", cs_n[0], 1'b1);
      chk("async reset wr_n", wr_n[0], 1'b1);
      chk("async reset oe", oe[0], 1'b0);
      chk("async reset waitrequest", waitreq[0], 1'b1);
      cs[0] = 1'b0; wr[0] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      txn(0, 1'b1, 1'b0, 2'd2, 16'h0);
      chk("post-reset read strobe last", r_slast, SLST_LIT[0]);
      @(negedge clk);
      go_idle(0, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
